// File: rtl/flow_ctrl_pkg.sv
// rtl/flow_ctrl_pkg.sv - shared opcodes, encodings and FSM states for the datapath controller
package flow_ctrl_pkg;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int REG_W  = 4;
  localparam int IMM8_W = 8;

  localparam logic [OP_W-1:0] OP_LDI  = 4'h8;
  localparam logic [OP_W-1:0] OP_LD   = 4'h9;
  localparam logic [OP_W-1:0] OP_ST   = 4'hA;
  localparam logic [OP_W-1:0] OP_PUSH = 4'hB;
  localparam logic [OP_W-1:0] OP_POP  = 4'hC;
  localparam logic [OP_W-1:0] OP_BR   = 4'hD;
  localparam logic [OP_W-1:0] OP_PLOT = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  localparam logic [REG_W-1:0] COND_ALWAYS = 4'h0;
  localparam logic [REG_W-1:0] COND_Z      = 4'h1;
  localparam logic [REG_W-1:0] COND_NZ     = 4'h2;
  localparam logic [REG_W-1:0] COND_S      = 4'h3;
  localparam logic [REG_W-1:0] COND_OFL    = 4'h4;
  localparam logic [REG_W-1:0] COND_ERR    = 4'h5;

  localparam logic [1:0] LOAD_NONE = 2'b00;
  localparam logic [1:0] LOAD_ALU  = 2'b01;
  localparam logic [1:0] LOAD_MEM  = 2'b10;
  localparam logic [1:0] LOAD_STK  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'h0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_PLOT_WAIT,
    ST_HALT
  } state_t;
endpackage

// File: rtl/datapath_controller_if.sv
// rtl/datapath_controller_if.sv - control/status bundle between the controller and the datapath
interface datapath_controller_if;
  import flow_ctrl_pkg::*;

  logic [DATA_W-1:0] current_instruction;
  logic [DATA_W-1:0] signflag;
  logic [DATA_W-1:0] zeroflag;
  logic [DATA_W-1:0] overflow;
  logic [DATA_W-1:0] errorbit;
  logic              vga_ready;

  logic              program_counter_increment;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a_altern;
  logic [DATA_W-1:0] alu_b_altern;
  logic [REG_W-1:0]  alu_a_select;
  logic [REG_W-1:0]  alu_b_select;
  logic [REG_W-1:0]  alu_out_select;
  logic              alu_a_source;
  logic              alu_b_source;
  logic [1:0]        alu_load_src;
  logic              alu_store_to_mem;
  logic              alu_store_to_stk;
  logic [REG_W-1:0]  vga_color_select;
  logic [REG_W-1:0]  vga_coord_select;
  logic              vga_plot;
  logic              halted;
  logic              plot_timeout;

  modport master (
    input  current_instruction, signflag, zeroflag, overflow, errorbit, vga_ready,
    output program_counter_increment, alu_op, alu_a_altern, alu_b_altern,
           alu_a_select, alu_b_select, alu_out_select, alu_a_source, alu_b_source,
           alu_load_src, alu_store_to_mem, alu_store_to_stk,
           vga_color_select, vga_coord_select, vga_plot, halted, plot_timeout
  );

  modport slave (
    output current_instruction, signflag, zeroflag, overflow, errorbit, vga_ready,
    input  program_counter_increment, alu_op, alu_a_altern, alu_b_altern,
           alu_a_select, alu_b_select, alu_out_select, alu_a_source, alu_b_source,
           alu_load_src, alu_store_to_mem, alu_store_to_stk,
           vga_color_select, vga_coord_select, vga_plot, halted, plot_timeout
  );
endinterface

// File: rtl/branch_condition_eval.sv
// rtl/branch_condition_eval.sv - combinational branch condition check against per-register flags
module branch_condition_eval
  import flow_ctrl_pkg::*;
(
  input  logic [REG_W-1:0]  cond,
  input  logic [REG_W-1:0]  ra,
  input  logic [DATA_W-1:0] signflag,
  input  logic [DATA_W-1:0] zeroflag,
  input  logic [DATA_W-1:0] overflow,
  input  logic [DATA_W-1:0] errorbit,
  output logic              taken
);
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = zeroflag[ra];
      COND_NZ:     taken = ~zeroflag[ra];
      COND_S:      taken = signflag[ra];
      COND_OFL:    taken = overflow[ra];
      COND_ERR:    taken = errorbit[ra];
      default:     taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/datapath_controller.sv
// rtl/datapath_controller.sv - instruction decode and sequencing FSM driving the datapath controls
module datapath_controller
  import flow_ctrl_pkg::*;
#(
  parameter int PLOT_TIMEOUT = 1023
) (
  input logic clock,
  input logic reset,
  datapath_controller_if.master dp
);
  localparam int CNT_W = $clog2(PLOT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PLOT_TIMEOUT - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] ir;
  logic [CNT_W-1:0]  wait_cnt;
  logic              plot_timeout_q;
  logic              taken;
  logic              plot_expire;

  logic [OP_W-1:0]   op;
  logic [REG_W-1:0]  rd, ra, rb;
  logic [DATA_W-1:0] imm8_ext, imm4_ext;

  assign op       = ir[15:12];
  assign rd       = ir[11:8];
  assign ra       = ir[7:4];
  assign rb       = ir[3:0];
  assign imm8_ext = {{(DATA_W-IMM8_W){1'b0}}, ir[IMM8_W-1:0]};
  assign imm4_ext = {{(DATA_W-REG_W){1'b0}}, rb};

  // Last permitted wait cycle with no acceptance: abandon the plot.
  assign plot_expire = (wait_cnt == WAIT_LAST) && !dp.vga_ready;

  branch_condition_eval u_branch_condition_eval (
    .cond     (rd),
    .ra       (ra),
    .signflag (dp.signflag),
    .zeroflag (dp.zeroflag),
    .overflow (dp.overflow),
    .errorbit (dp.errorbit),
    .taken    (taken)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_FETCH;
      ir             <= '0;
      wait_cnt       <= '0;
      plot_timeout_q <= 1'b0;
    end else begin
      state    <= state_next;
      if (state == ST_FETCH) ir <= dp.current_instruction;
      wait_cnt <= (state == ST_PLOT_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == ST_PLOT_WAIT && plot_expire) plot_timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_LD, OP_POP: state_next = ST_WB;
          OP_PLOT:       state_next = ST_PLOT_WAIT;
          OP_HALT:       state_next = ST_HALT;
          default:       state_next = ST_FETCH;
        endcase
      end
      ST_WB:        state_next = ST_FETCH;
      ST_PLOT_WAIT: if (dp.vga_ready || plot_expire) state_next = ST_FETCH;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    dp.program_counter_increment = 1'b0;
    dp.alu_op           = ALU_ADD;
    dp.alu_a_altern     = '0;
    dp.alu_b_altern     = '0;
    dp.alu_a_select     = '0;
    dp.alu_b_select     = '0;
    dp.alu_out_select   = '0;
    dp.alu_a_source     = 1'b0;
    dp.alu_b_source     = 1'b0;
    dp.alu_load_src     = LOAD_NONE;
    dp.alu_store_to_mem = 1'b0;
    dp.alu_store_to_stk = 1'b0;
    dp.vga_color_select = '0;
    dp.vga_coord_select = '0;
    dp.vga_plot         = 1'b0;
    dp.halted           = (state == ST_HALT);
    dp.plot_timeout     = plot_timeout_q;
    case (state)
      ST_EXEC: begin
        dp.program_counter_increment = 1'b1;
        case (op)
          OP_LDI: begin
            dp.alu_a_altern   = imm8_ext;
            dp.alu_a_source   = 1'b1;
            dp.alu_b_source   = 1'b1;
            dp.alu_load_src   = LOAD_ALU;
            dp.alu_out_select = rd;
            dp.program_counter_increment = (rd != '0);
          end
          OP_LD, OP_POP, OP_ST, OP_PUSH: begin
            dp.alu_a_select     = ra;
            dp.alu_b_altern     = imm4_ext;
            dp.alu_b_source     = 1'b1;
            dp.alu_out_select   = rd;
            dp.alu_store_to_mem = (op == OP_ST);
            dp.alu_store_to_stk = (op == OP_PUSH);
          end
          OP_BR: begin
            // Taken branch writes Rrb + 0 into R0 (the PC).
            if (taken) begin
              dp.alu_a_select = rb;
              dp.alu_b_source = 1'b1;
              dp.alu_load_src = LOAD_ALU;
              dp.program_counter_increment = 1'b0;
            end
          end
          OP_PLOT: begin
            dp.vga_color_select = rd;
            dp.vga_coord_select = ra;
          end
          OP_HALT: ;
          default: begin
            dp.alu_op         = {1'b0, op[2:0]};
            dp.alu_a_select   = ra;
            dp.alu_b_select   = rb;
            dp.alu_load_src   = LOAD_ALU;
            dp.alu_out_select = rd;
            dp.program_counter_increment = (rd != '0);
          end
        endcase
      end
      ST_WB: begin
        dp.alu_a_select   = ra;
        dp.alu_b_altern   = imm4_ext;
        dp.alu_b_source   = 1'b1;
        dp.alu_out_select = rd;
        dp.alu_load_src   = (op == OP_LD) ? LOAD_MEM : LOAD_STK;
      end
      ST_PLOT_WAIT: begin
        dp.vga_color_select = rd;
        dp.vga_coord_select = ra;
        dp.vga_plot         = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_datapath_controller.sv
// tb/tb_datapath_controller.sv - scoreboard bench for datapath_controller with a rule-level model
module tb_datapath_controller;
  typedef struct packed {
    logic        inc;
    logic [3:0]  alu_op;
    logic [15:0] a_alt;
    logic [15:0] b_alt;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic [3:0]  out_sel;
    logic        a_src;
    logic        b_src;
    logic [1:0]  load;
    logic        st_mem;
    logic        st_stk;
    logic [3:0]  color;
    logic [3:0]  coord;
    logic        plot;
    logic        halted;
    logic        pto;
  } ctl_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  datapath_controller_if dpi ();
  datapath_controller #(.PLOT_TIMEOUT(1023)) dut (.clock(clock), .reset(reset), .dp(dpi));

  ctl_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  m_halted = 1'b0;
  logic  m_pto = 1'b0;
  ctl_t  mon_exp;
  string mon_tag;

  function automatic ctl_t sample();
    ctl_t s;
    s.inc     = dpi.program_counter_increment;
    s.alu_op  = dpi.alu_op;
    s.a_alt   = dpi.alu_a_altern;
    s.b_alt   = dpi.alu_b_altern;
    s.a_sel   = dpi.alu_a_select;
    s.b_sel   = dpi.alu_b_select;
    s.out_sel = dpi.alu_out_select;
    s.a_src   = dpi.alu_a_source;
    s.b_src   = dpi.alu_b_source;
    s.load    = dpi.alu_load_src;
    s.st_mem  = dpi.alu_store_to_mem;
    s.st_stk  = dpi.alu_store_to_stk;
    s.color   = dpi.vga_color_select;
    s.coord   = dpi.vga_coord_select;
    s.plot    = dpi.vga_plot;
    s.halted  = dpi.halted;
    s.pto     = dpi.plot_timeout;
    return s;
  endfunction

  function automatic ctl_t idle_rec();
    ctl_t r = '0;
    r.halted = m_halted;
    r.pto    = m_pto;
    return r;
  endfunction

  task automatic check(input string name, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input ctl_t r, input string t);
    exp_q.push_back(r);
    tag_q.push_back(t);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      check(mon_tag, sample(), mon_exp);
    end
  end

  // Called at the start of a FETCH cycle; plot_delay < 0 means the plotter never answers.
  task automatic run_instr(input logic [15:0] ins, input int plot_delay);
    logic [3:0] op, rd, ra, rb;
    ctl_t e, w;
    int len, waits;
    logic taken;
    op = ins[15:12]; rd = ins[11:8]; ra = ins[7:4]; rb = ins[3:0];
    push(idle_rec(), "fetch");
    len = 1;
    e = idle_rec();
    e.inc = 1'b1;
    case (op)
      4'h8: begin
        e.a_alt = {8'h00, ins[7:0]}; e.a_src = 1'b1; e.b_src = 1'b1;
        e.load = 2'b01; e.out_sel = rd; e.inc = (rd != 4'h0);
        push(e, "ldi"); len += 1;
      end
      4'h9, 4'hC: begin
        e.a_sel = ra; e.b_alt = {12'h000, rb}; e.b_src = 1'b1; e.out_sel = rd;
        push(e, "ld_addr");
        w = e; w.inc = 1'b0; w.load = (op == 4'h9) ? 2'b10 : 2'b11;
        push(w, "ld_wb"); len += 2;
      end
      4'hA, 4'hB: begin
        e.a_sel = ra; e.b_alt = {12'h000, rb}; e.b_src = 1'b1; e.out_sel = rd;
        e.st_mem = (op == 4'hA); e.st_stk = (op == 4'hB);
        push(e, "store"); len += 1;
      end
      4'hD: begin
        case (rd)
          4'h0:    taken = 1'b1;
          4'h1:    taken = dpi.zeroflag[ra];
          4'h2:    taken = !dpi.zeroflag[ra];
          4'h3:    taken = dpi.signflag[ra];
          4'h4:    taken = dpi.overflow[ra];
          4'h5:    taken = dpi.errorbit[ra];
          default: taken = 1'b0;
        endcase
        if (taken) begin
          e.a_sel = rb; e.b_src = 1'b1; e.load = 2'b01; e.out_sel = 4'h0; e.inc = 1'b0;
        end
        push(e, taken ? "br_taken" : "br_not_taken"); len += 1;
      end
      4'hE: begin
        e.color = rd; e.coord = ra;
        push(e, "plot_exec");
        w = idle_rec(); w.color = rd; w.coord = ra; w.plot = 1'b1;
        waits = (plot_delay < 0) ? 1023 : plot_delay + 1;
        repeat (waits) push(w, "plot_wait");
        len += 1 + waits;
        if (plot_delay < 0) m_pto = 1'b1;
      end
      4'hF: begin
        push(e, "halt_exec");
        m_halted = 1'b1;
        repeat (100) push(idle_rec(), "halted");
        len += 101;
      end
      default: begin
        e.alu_op = op; e.a_sel = ra; e.b_sel = rb; e.load = 2'b01;
        e.out_sel = rd; e.inc = (rd != 4'h0);
        push(e, "alu"); len += 1;
      end
    endcase
    dpi.current_instruction = ins;
    for (int c = 1; c <= len; c++) begin
      dpi.vga_ready = (op == 4'hE) && (plot_delay >= 0) && (c == len);
      @(posedge clock);
      #1;
    end
    dpi.vga_ready = 1'b0;
  endtask

  initial begin
    ctl_t e;
    reset = 1'b1;
    dpi.current_instruction = '0;
    dpi.signflag = '0; dpi.zeroflag = '0; dpi.overflow = '0; dpi.errorbit = '0;
    dpi.vga_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", sample(), idle_rec());
    reset = 1'b0;

    for (int i = 0; i < 80; i++) begin
      dpi.signflag = 16'($urandom); dpi.zeroflag = 16'($urandom);
      dpi.overflow = 16'($urandom); dpi.errorbit = 16'($urandom);
      run_instr({4'($urandom_range(0, 14)), 12'($urandom)}, int'($urandom_range(0, 4)));
    end

    run_instr(16'h8312, 0);
    run_instr(16'h9125, 0);
    run_instr(16'h8000, 0);
    run_instr(16'hC3A7, 0);
    dpi.zeroflag = 16'h0010;
    run_instr(16'hD147, 0);
    dpi.zeroflag = 16'hFFEF;
    run_instr(16'hD147, 0);
    run_instr(16'hD6F1, 0);
    run_instr(16'hE560, 3);
    run_instr(16'hE560, 0);
    run_instr(16'hE560, -1);
    run_instr(16'h1234, 0);

    // Store aborted by reset in the middle of its EXEC cycle.
    dpi.current_instruction = 16'hA318;
    @(posedge clock);
    #1;
    e = idle_rec();
    e.inc = 1'b1; e.a_sel = 4'h1; e.b_alt = 16'h0008; e.b_src = 1'b1;
    e.out_sel = 4'h3; e.st_mem = 1'b1;
    check("st_exec", sample(), e);
    #2;
    reset = 1'b1;
    m_pto = 1'b0;
    m_halted = 1'b0;
    #1;
    check("st_reset_async", sample(), idle_rec());
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #2;
      check("st_under_reset", sample(), idle_rec());
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_instr(16'hB2C4, 0);

    run_instr(16'h8312, 0);
    run_instr(16'hF000, 0);
    reset = 1'b1;
    m_halted = 1'b0;
    m_pto = 1'b0;
    #1;
    check("halt_reset", sample(), idle_rec());
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_instr(16'h8312, 0);

    @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
